// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// One response (read data or write ack) per accepted request.
interface load_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [3:0]            req_wstrb;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: runs one decoded memory access on the data bus and stalls the pipeline
// meanwhile. Define LSU_TIMEOUT_EN to abort a response wait after TIMEOUT_CYCLES cycles.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  mem_write_i,
    input  logic                  mem_to_reg_i,
    input  logic                  reg_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    load_store_unit_if.master     bus,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  load_valid_o,
    output logic [31:0]           load_data_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StDone} state_e;

    state_e                state_q, state_d;
    logic                  is_load_q, is_load_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;
    logic                  req_valid_q, req_valid_d;
    logic                  req_we_q, req_we_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [31:0]           req_wdata_q, req_wdata_d;
    logic [3:0]            req_wstrb_q, req_wstrb_d;
    logic                  done_q, done_d;
    logic                  load_valid_q, load_valid_d;
    logic [31:0]           load_data_q, load_data_d;
    logic                  err_q, err_d;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    logic        is_store, is_load, accept, legal;
    logic [3:0]  wstrb_enc;
    logic [31:0] wdata_enc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // A set mem_write masks mem_to_reg; loads also need reg_write.
    assign is_store = mem_write_i;
    assign is_load  = ~mem_write_i & mem_to_reg_i & reg_write_i;
    assign accept   = valid_i & (is_store | is_load);

    always_comb begin
        legal = 1'b0;
        case (funct3_i)
            3'd0:       legal = 1'b1;
            3'd1:       legal = ~addr_i[0];
            3'd2:       legal = (addr_i[1:0] == 2'b00);
            3'd4:       legal = is_load;
            3'd5:       legal = is_load & ~addr_i[0];
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3_i[1:0])
            2'd0: begin
                wstrb_enc = 4'b0001 << addr_i[1:0];
                wdata_enc = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                wstrb_enc = 4'b0011 << addr_i[1:0];
                wdata_enc = {2{wdata_i[15:0]}};
            end
            default: begin
                wstrb_enc = 4'b1111;
                wdata_enc = wdata_i;
            end
        endcase
    end

    assign ld_byte = bus.rsp_rdata[{off_q, 3'b000} +: 8];
    assign ld_half = off_q[1] ? bus.rsp_rdata[31:16] : bus.rsp_rdata[15:0];

    always_comb begin
        case (funct3_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_ext = {24'h0, ld_byte};
            3'd5:    ld_ext = {16'h0, ld_half};
            default: ld_ext = bus.rsp_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        load_data_d = load_data_q;
        err_d       = err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    is_load_d = is_load;
                    funct3_d  = funct3_i;
                    off_d     = addr_i[1:0];
                    if (legal) begin
                        state_d     = StReq;
                        req_valid_d = 1'b1;
                        req_we_d    = is_store;
                        req_addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        req_wstrb_d = is_store ? wstrb_enc : 4'b0000;
                        req_wdata_d = is_store ? wdata_enc : 32'h0;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StReq: begin
                if (bus.req_ready) begin
                    state_d     = StWaitRsp;
                    req_valid_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            StWaitRsp: begin
                if (bus.rsp_valid) begin
                    state_d = StDone;
                    if (is_load_q) begin
                        load_data_d = ld_ext;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
        done_d       = (state_d == StDone);
        load_valid_d = done_d & is_load_d & ~err_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            req_valid_q  <= 1'b0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= 32'h0;
            req_wstrb_q  <= 4'h0;
            done_q       <= 1'b0;
            load_valid_q <= 1'b0;
            load_data_q  <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_load_q    <= is_load_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            req_valid_q  <= req_valid_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_wstrb_q  <= req_wstrb_d;
            done_q       <= done_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            err_q        <= err_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign stall_o = ((state_q == StIdle) & accept) | (state_q == StReq) |
                     (state_q == StWaitRsp);

    assign bus.req_valid = req_valid_q;
    assign bus.req_we    = req_we_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_wdata = req_wdata_q;
    assign bus.req_wstrb = req_wstrb_q;
    assign done_o        = done_q;
    assign load_valid_o  = load_valid_q;
    assign load_data_o   = load_data_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner sequences and
// random accesses checked against an arithmetic model of the access rules.
module tb_load_store_unit;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, mem_write, mem_to_reg, reg_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, load_valid, err;
    logic [31:0] load_data;

    load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

    load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid),
        .mem_write_i  (mem_write),
        .mem_to_reg_i (mem_to_reg),
        .reg_write_i  (reg_write),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .bus          (bus),
        .stall_o      (stall),
        .done_o       (done),
        .load_valid_o (load_valid),
        .load_data_o  (load_data),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_ld;

    typedef struct {
        bit          mw, mtr, rw;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd;
        int          rdy_wait, rsp_lat;
    } op_t;

    typedef struct {
        bit          req, we;
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        bit          err, lv;
        logic [31:0] ld;
        int          lat;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t e;
    } vec_t;

    typedef struct {
        bit          done_seen, req, we, err, lv, stable, pulse_ok;
        logic [31:0] addr, wdata, ld;
        logic [3:0]  wstrb;
        int          lat, stall_cnt;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(bit mw, bit mtr, bit rw, logic [2:0] f3, logic [31:0] a,
                                 logic [31:0] wd, logic [31:0] rd, int rdy, int rl,
                                 bit req, bit we, logic [31:0] ea, logic [31:0] ewd,
                                 logic [3:0] es, bit er, bit lv, logic [31:0] ld, int lat);
        vec_t v;
        v.op = '{mw: mw, mtr: mtr, rw: rw, f3: f3, a: a, wd: wd, rd: rd,
                 rdy_wait: rdy, rsp_lat: rl};
        v.e  = '{req: req, we: we, addr: ea, wdata: ewd, wstrb: es, err: er, lv: lv,
                 ld: ld, lat: lat};
        return v;
    endfunction

    // Expected result of one accepted access, straight from the access rules.
    function automatic exp_t model(input op_t op, input logic [31:0] prev_ld);
        exp_t        e;
        bit          store, legal;
        int unsigned lane, sz;
        logic [31:0] v, span;
        store = op.mw;
        lane  = op.a % 4;
        sz    = op.f3 % 4;
        if (store) legal = (op.f3 <= 2);
        else       legal = (op.f3 != 3) && (op.f3 < 6);
        if (sz == 1 && (op.a % 2) != 0) legal = 0;
        if (sz == 2 && lane != 0) legal = 0;
        e = '{default: 0};
        e.req  = legal;
        e.we   = store;
        e.addr = op.a - lane;
        if (store) begin
            if (sz == 0) begin
                e.wdata = (op.wd % 256) * 32'h01010101;
                e.wstrb = 4'(1 << lane);
            end else if (sz == 1) begin
                e.wdata = (op.wd % 65536) * 32'h00010001;
                e.wstrb = 4'(3 << lane);
            end else begin
                e.wdata = op.wd;
                e.wstrb = 4'hF;
            end
        end
        if (!store && legal) begin
            if (sz == 0) begin
                span = 256;
                v    = (op.rd >> (8 * lane)) % 256;
            end else if (sz == 1) begin
                span = 65536;
                v    = (op.rd >> (16 * (lane / 2))) % 65536;
            end else begin
                span = 0;
                v    = op.rd;
            end
            if (op.f3 < 2 && v >= span / 2) v = v - span;
            e.ld = v;
        end else begin
            e.ld = prev_ld;
        end
        e.err = !legal;
        e.lv  = !store && legal;
        e.lat = legal ? 3 + op.rdy_wait + op.rsp_lat : 1;
        return e;
    endfunction

    // Presents one access and plays the memory side, observing the DUT each cycle.
    task automatic run_op(input op_t op, input int max_cyc, output obs_t o);
        int waited = 0;
        int hs_cyc = -1;
        bit rsp_given = 0;
        o = '{default: 0};
        o.stable = 1;
        o.lat = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (c == 0) begin
                valid = 1; mem_write = op.mw; mem_to_reg = op.mtr; reg_write = op.rw;
                funct3 = op.f3; addr = op.a; wdata = op.wd;
            end else begin
                valid = 0;
            end
            bus.req_ready = 0;
            bus.rsp_valid = 0;
            bus.rsp_rdata = op.rd;
            #1;
            if (stall) o.stall_cnt++;
            if (done) begin
                o.done_seen = 1; o.lat = c; o.err = err; o.lv = load_valid; o.ld = load_data;
                break;
            end
            if (bus.req_valid) begin
                if (!o.req) begin
                    o.req = 1; o.we = bus.req_we; o.addr = bus.req_addr;
                    o.wdata = bus.req_wdata; o.wstrb = bus.req_wstrb;
                end else if (bus.req_we !== o.we || bus.req_addr !== o.addr ||
                             bus.req_wdata !== o.wdata || bus.req_wstrb !== o.wstrb) begin
                    o.stable = 0;
                end
                if (hs_cyc < 0 && waited >= op.rdy_wait) begin
                    bus.req_ready = 1;
                    hs_cyc = c;
                end else begin
                    waited++;
                end
            end
            if (hs_cyc >= 0 && !rsp_given && c == hs_cyc + 1 + op.rsp_lat) begin
                bus.rsp_valid = 1;
                rsp_given = 1;
            end
        end
        if (o.done_seen) begin
            @(negedge clk);
            valid = 0; bus.req_ready = 0; bus.rsp_valid = 0;
            #1;
            o.pulse_ok = !done && !stall && !err && !load_valid;
        end
    endtask

    task automatic apply(input string tag, input op_t op, input exp_t e);
        obs_t o;
        run_op(op, 40, o);
        check({tag, " done_seen"}, o.done_seen, 1);
        check({tag, " latency"}, o.lat, e.lat);
        check({tag, " stall_cycles"}, o.stall_cnt, e.lat);
        check({tag, " req_issued"}, o.req, e.req);
        if (e.req) begin
            check({tag, " req_we"}, o.we, e.we);
            check({tag, " req_addr"}, o.addr, e.addr);
            check({tag, " req_wstrb"}, o.wstrb, e.wstrb);
            if (e.we) check({tag, " req_wdata"}, o.wdata, e.wdata);
            check({tag, " req_stable"}, o.stable, 1);
        end
        check({tag, " err"}, o.err, e.err);
        check({tag, " load_valid"}, o.lv, e.lv);
        check({tag, " load_data"}, o.ld, e.ld);
        check({tag, " done_pulse"}, o.pulse_ok, 1);
        model_ld = e.ld;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_ld = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        op_t  op;
        obs_t o;

        vecs[0]  = mkv(0,1,1,3'd2,'h100,0,'hDEADBEEF,0,0, 1,0,'h100,0,4'h0, 0,1,'hDEADBEEF,3);
        vecs[1]  = mkv(0,1,1,3'd0,'h103,0,'h80FF1234,0,0, 1,0,'h100,0,4'h0, 0,1,'hFFFFFF80,3);
        vecs[2]  = mkv(0,1,1,3'd4,'h103,0,'h80FF1234,0,0, 1,0,'h100,0,4'h0, 0,1,'h00000080,3);
        vecs[3]  = mkv(0,1,1,3'd5,'h102,0,'h80FF1234,0,0, 1,0,'h100,0,4'h0, 0,1,'h000080FF,3);
        vecs[4]  = mkv(1,0,0,3'd0,'h201,'hAB,0,0,0, 1,1,'h200,'hABABABAB,4'b0010,
                       0,0,'h000080FF,3);
        vecs[5]  = mkv(1,0,0,3'd2,'h302,'h11223344,0,0,0, 0,0,0,0,4'h0, 1,0,'h000080FF,1);
        vecs[6]  = mkv(0,1,1,3'd1,'h102,0,'h80015555,4,0, 1,0,'h100,0,4'h0, 0,1,'hFFFF8001,7);
        vecs[7]  = mkv(1,0,0,3'd1,'h106,'h1234ABCD,0,0,2, 1,1,'h104,'hABCDABCD,4'b1100,
                       0,0,'hFFFF8001,5);
        vecs[8]  = mkv(0,1,1,3'd2,'h101,0,0,0,0, 0,0,0,0,4'h0, 1,0,'hFFFF8001,1);
        vecs[9]  = mkv(0,1,1,3'd3,'h000,0,0,0,0, 0,0,0,0,4'h0, 1,0,'hFFFF8001,1);
        vecs[10] = mkv(1,0,0,3'd4,'h000,0,0,0,0, 0,0,0,0,4'h0, 1,0,'hFFFF8001,1);
        vecs[11] = mkv(1,1,1,3'd0,'h003,'h5A,'hFFFFFFFF,1,1, 1,1,'h000,'h5A5A5A5A,4'b1000,
                       0,0,'hFFFF8001,5);
        vecs[12] = mkv(0,1,1,3'd1,'h101,0,0,0,0, 0,0,0,0,4'h0, 1,0,'hFFFF8001,1);
        vecs[13] = mkv(0,1,1,3'd0,'h201,0,'h00007F00,2,3, 1,0,'h200,0,4'h0, 0,1,'h0000007F,8);

        rst = 1;
        valid = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
        funct3 = 0; addr = 0; wdata = 0;
        bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_rdata = 0;
        model_ld = 0;
        repeat (2) @(negedge clk);
        check("reset stall", stall, 0);
        check("reset done", done, 0);
        check("reset req_valid", bus.req_valid, 0);
        check("reset req_we", bus.req_we, 0);
        check("reset req_addr", bus.req_addr, 0);
        check("reset req_wdata", bus.req_wdata, 0);
        check("reset req_wstrb", bus.req_wstrb, 0);
        check("reset load_valid", load_valid, 0);
        check("reset load_data", load_data, 0);
        check("reset err", err, 0);
        rst = 0;

        for (int i = 0; i < 14; i++) apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].e);

        // Requests that must not be accepted.
        @(negedge clk);
        valid = 1; mem_write = 0; mem_to_reg = 1; reg_write = 0;
        #1;
        check("noacc load_no_regwrite stall", stall, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("noacc req_valid", bus.req_valid, 0);
            check("noacc done", done, 0);
        end
        @(negedge clk);
        valid = 0; mem_write = 1;
        #1;
        check("noacc invalid stall", stall, 0);
        @(negedge clk); #1;
        check("noacc invalid req_valid", bus.req_valid, 0);
        mem_write = 0;

        // Reset while waiting for a response; the late response must be ignored.
        @(negedge clk);
        valid = 1; mem_write = 0; mem_to_reg = 1; reg_write = 1; funct3 = 3'd2; addr = 'h40;
        bus.req_ready = 1;
        @(negedge clk);
        valid = 0;
        #1;
        check("rstwait req_valid", bus.req_valid, 1);
        @(negedge clk);
        bus.req_ready = 0;
        #1;
        check("rstwait in_wait stall", stall, 1);
        rst = 1;
        #1;
        check("rstwait stall", stall, 0);
        check("rstwait req_valid_off", bus.req_valid, 0);
        check("rstwait req_addr", bus.req_addr, 0);
        check("rstwait load_data", load_data, 0);
        check("rstwait done", done, 0);
        @(negedge clk);
        rst = 0;
        model_ld = 0;
        bus.rsp_valid = 1; bus.rsp_rdata = 'h12345678;
        @(negedge clk);
        bus.rsp_valid = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("late_rsp done", done, 0);
            check("late_rsp stall", stall, 0);
            check("late_rsp load_data", load_data, 0);
            @(negedge clk);
        end

        // Response that never comes.
        op = '{mw: 0, mtr: 1, rw: 1, f3: 3'd2, a: 'h80, wd: 0, rd: 'hCAFEF00D,
               rdy_wait: 0, rsp_lat: 1000};
`ifdef LSU_TIMEOUT_EN
        run_op(op, 40, o);
        check("timeout done_seen", o.done_seen, 1);
        check("timeout latency", o.lat, 2 + TO);
        check("timeout stall_cycles", o.stall_cnt, 2 + TO);
        check("timeout err", o.err, 1);
        check("timeout load_valid", o.lv, 0);
        check("timeout load_data", o.ld, model_ld);
        check("timeout done_pulse", o.pulse_ok, 1);
        op.rsp_lat = TO - 1;
        apply("rsp_at_limit", op, model(op, model_ld));
`else
        run_op(op, 30, o);
        check("no_timeout done_seen", o.done_seen, 0);
        check("no_timeout stall_cycles", o.stall_cnt, 30);
        pulse_reset();
`endif

        for (int i = 0; i < 60; i++) begin
            bit st;
            st = bit'($urandom_range(0, 1));
            op.mw  = st;
            op.mtr = st ? bit'($urandom_range(0, 1)) : 1'b1;
            op.rw  = st ? bit'($urandom_range(0, 1)) : 1'b1;
            op.f3  = 3'($urandom_range(0, 7));
            op.a   = $urandom;
            if ($urandom_range(0, 1) == 1) op.a[1:0] = 2'b00;
            op.wd  = $urandom;
            op.rd  = $urandom;
            op.rdy_wait = int'($urandom_range(0, 3));
            op.rsp_lat  = int'($urandom_range(0, 3));
            apply($sformatf("rand%0d", i), op, model(op, model_ld));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Consumer end of the main control decode: takes the decoded memory-control signals (mem_write, mem_to_reg, reg_write), funct3 and the ALU-computed address, and executes the access on a valid/ready data-memory bus.
- Sits between the execute stage and data memory. Stalls the pipeline for the whole access. Returns sign/zero-extended load data to the writeback mux.

Parameters:
- ADDR_WIDTH, 32, byte-address width of addr and req_addr. Data width is fixed at 32.
- TIMEOUT_CYCLES, 255, response-wait limit; used only with LSU_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid  input  1  instruction in execute is valid.
- mem_write  input  1  store request from the control unit.
- mem_to_reg  input  1  load request from the control unit; qualified by reg_write.
- reg_write  input  1  from the control unit.
- funct3  input  3  access size/sign: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- addr  input  ADDR_WIDTH  effective byte address.
- wdata  input  32  store data (rs2).
- req_valid  output  1  bus request valid.
- req_ready  input  1  bus accepts request.
- req_we  output  1  1=write, 0=read.
- req_addr  output  ADDR_WIDTH  word-aligned address.
- req_wdata  output  32  lane-replicated store data.
- req_wstrb  output  4  byte enables.
- rsp_valid  input  1  read data or write ack (one per request).
- rsp_rdata  input  32  read data word.
- stall  output  1  hold pipeline.
- done  output  1  one-cycle access-complete pulse.
- load_valid  output  1  load_data valid (with done, loads only).
- load_data  output  32  extended load result.
- err  output  1  misaligned, illegal funct3, or timeout; valid with done.

Behaviour:
- Reset: state IDLE; all registered outputs 0 (req_valid, req_we, req_addr, req_wdata, req_wstrb, done, load_valid, load_data, err); timeout counter 0. Reset mid-access abandons the access; a late rsp_valid arriving in IDLE is ignored.
- Accept: in IDLE when valid && (mem_write || (mem_to_reg && reg_write)). mem_write has priority and mem_to_reg is ignored when it is set.
- On accept, latch op, funct3, addr[1:0] and wdata.
- Legality check on accept:
  - Store funct3 must be 0-2; load funct3 must be 0, 1, 2, 4 or 5.
  - H requires addr[0]=0; W requires addr[1:0]=0.
  - Illegal → go to DONE with err=1, no bus request.
  - Legal → go to REQ.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
  - REQ: req_valid=1. All req_* fields stay stable until a cycle with req_valid && req_ready, then go to WAIT_RSP.
  - WAIT_RSP: req_valid=0. On rsp_valid go to DONE.
  - DONE: go to IDLE unconditionally. valid is not sampled in DONE.
  - rsp_valid is ignored outside WAIT_RSP.
- stall (combinational) = (IDLE && accept) || REQ || WAIT_RSP. stall is 0 in DONE so the instruction retires.
- done=1 for exactly the DONE cycle. load_valid=done && load && !err. err is cleared on leaving DONE.
- Minimum latency, with req_ready=1 and rsp_valid the cycle after the handshake:
  - accept cycle N; REQ handshake N+1; rsp N+2; DONE N+3.
  - stall high for 3 cycles.
- Address: req_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
- Write encoding:
  - req_wstrb: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111.
  - req_wdata: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
- Loads: req_wstrb=0 and req_we=0.
- Load extraction, registered on rsp_valid:
  - Byte = rsp_rdata[8*addr[1:0] +: 8]; half = rsp_rdata[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- load_data holds its value until the next load completes.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- When defined, a counter clears on entering WAIT_RSP and increments each WAIT_RSP cycle without rsp_valid. When the count reaches TIMEOUT_CYCLES, go to DONE with err=1 and load_valid=0. rsp_valid in the same cycle as the limit wins: normal completion.
- When undefined, there is no counter and WAIT_RSP waits indefinitely.

Test Plan:
- LW at addr 0x100, req_ready=1, rsp_rdata=0xDEADBEEF next cycle → req_addr=0x100, req_we=0, stall high 3 cycles, done with load_data=0xDEADBEEF, load_valid=1.
- LB at addr 0x103, rdata=0x80FF1234 → load_data=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB at addr 0x201, wdata=0x000000AB → req_wdata=0xABABABAB, req_wstrb=4'b0010, req_we=1, req_addr=0x200. done with load_valid=0.
- SW at addr 0x302 → no req_valid; done with err=1 one cycle after accept; stall high 1 cycle.
- LH with req_ready low for 4 cycles → req_valid and all req_* fields held constant until ready. rst asserted in WAIT_RSP → all outputs 0 immediately; a following rsp_valid is ignored.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, no rsp_valid → done with err=1 after 8 WAIT_RSP cycles. Without the macro → stall remains high.
